// File: rtl/data_memory.sv
// Line-granular off-chip data memory model for the L1 data cache.
// One request at a time; single-cycle ack_o a fixed LATENCY edges after acceptance.
//
// state | meaning
// IDLE  | waiting for enable_i; latches index, write_i and data_i on acceptance
// BUSY  | counting down the access latency; inputs ignored
// ACK   | ack_o high for this cycle; returns to IDLE on the next edge
module data_memory #(
  parameter int LATENCY     = 10,
  parameter int DEPTH       = 512,
  parameter int ADDR_LINE_W = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
  output logic [255:0] data_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // Down-counter: loaded at acceptance so it reaches zero on the edge before
  // the access edge, which lands exactly LATENCY edges after acceptance.
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  logic [1:0]             state;
  logic [7:0]             cnt;
  logic [ADDR_LINE_W-1:0] idx_q;
  logic                   wr_q;
  logic [255:0]           wdata_q;
  logic                   access_now;
  logic                   mem_we;

  logic [255:0] mem [DEPTH];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:5+ADDR_LINE_W], addr_i[4:0]};

  assign access_now = (state == ST_BUSY) && (cnt == 8'd0);
  assign mem_we     = access_now && wr_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= ST_IDLE;
      cnt     <= 8'd0;
      ack_o   <= 1'b0;
      data_o  <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ack_o <= 1'b0;
          if (enable_i) begin
            idx_q   <= addr_i[5 +: ADDR_LINE_W];
            wr_q    <= write_i;
            wdata_q <= data_i;
            cnt     <= CNT_LOAD;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt == 8'd0) begin
            ack_o <= 1'b1;
            if (!wr_q) begin
              data_o <= mem[idx_q];
            end
            state <= ST_ACK;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_ACK: begin
          ack_o <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          ack_o <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Array is deliberately not reset so contents survive rst_i; a reset
  // forces state to IDLE, so a pending write can never reach this port.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: LATENCY=10 main instance plus a LATENCY=1 instance.
module tb_data_memory;

  localparam int LAT = 10;

  localparam logic [255:0] PAT_A5 = {32{8'hA5}};
  localparam logic [255:0] PAT_W1 = {{15{16'h1234}}, 16'hDEAD};
  localparam logic [255:0] PAT_W2 = {8{32'hCAFE_F00D}};
  localparam logic [255:0] PAT_P1 = {4{64'h0123_4567_89AB_CDEF}};

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         enable_i, write_i, ack_o;
  logic [31:0]  addr_i;
  logic [255:0] data_i, data_o;
  logic         en1, wr1, ack1;
  logic [31:0]  addr1;
  logic [255:0] din1, dout1;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [255:0] d;
    int           c;
  } exp_t;
  exp_t sbq[$];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  data_memory #(.LATENCY(LAT), .DEPTH(512), .ADDR_LINE_W(9)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .write_i(write_i),
    .addr_i(addr_i), .data_i(data_i), .ack_o(ack_o), .data_o(data_o)
  );

  data_memory #(.LATENCY(1), .DEPTH(512), .ADDR_LINE_W(9)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(en1), .write_i(wr1),
    .addr_i(addr1), .data_i(din1), .ack_o(ack1), .data_o(dout1)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk_i);
      if (rst_i === 1'b1 && ack_o === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: ack_o=1 at edge %0d, expected no ack", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("ack_data", data_o, e.d);
          chk("ack_edge", 256'(cyc), 256'(e.c));
        end
      end
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [255:0] d,
                       input logic [255:0] exp_d);
    @(negedge clk_i);
    enable_i = 1'b1;
    write_i  = w;
    addr_i   = a;
    data_i   = d;
    sbq.push_back('{exp_d, cyc + 1 + LAT});
  endtask

  task automatic wait_ack(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(negedge clk_i);
      if (ack_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: ack_o stayed 0, expected ack within %0d cycles", name, LAT + 20);
    end
  endtask

  task automatic req(input logic w, input logic [31:0] a, input logic [255:0] d,
                     input logic [255:0] exp_d, input string name);
    issue(w, a, d, exp_d);
    wait_ack(name);
    enable_i = 1'b0;
    write_i  = ~w;
    addr_i   = 32'hFFFF_FFFF;
    data_i   = ~d;
  endtask

  initial begin
    u_dut.mem[0]  = '0;
    u_dut.mem[3]  = PAT_A5;
    u_dut.mem[7]  = '0;
    u_dut.mem[32] = '0;
    u_dut1.mem[5] = PAT_P1;
    u_dut1.mem[6] = '0;

    rst_i = 1'b0;
    enable_i = 1'b1; write_i = 1'b0; addr_i = 32'h0000_0060; data_i = '0;
    en1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0;

    fork
      monitor();
    join_none

    // Reset held with enable_i high
    repeat (3) @(negedge clk_i);
    chk("rst_ack", 256'(ack_o), 256'(0));
    chk("rst_data", data_o, '0);
    enable_i = 1'b0;
    rst_i = 1'b1;

    // Read line 3, then check data_o holds after enable_i drops
    req(1'b0, 32'h0000_0060, '0, PAT_A5, "rd3");
    repeat (3) @(negedge clk_i);
    chk("hold_data", data_o, PAT_A5);

    // Write line 32, keep enable_i high and turn it into a read of the same line
    issue(1'b1, 32'h0000_0400, PAT_W1, PAT_A5);
    wait_ack("wr32");
    write_i = 1'b0;
    addr_i  = 32'h0000_0410;
    data_i  = '0;
    sbq.push_back('{PAT_W1, cyc + 2 + LAT});
    wait_ack("rd32");
    enable_i = 1'b0;

    // Offset bits inside the line are ignored
    req(1'b0, 32'h0000_007F, '0, PAT_A5, "rd3_off");

    // Index bits above the array size alias onto line 0
    req(1'b1, 32'h0000_4000, PAT_W2, PAT_A5, "wr_alias");
    req(1'b0, 32'h0000_0000, '0, PAT_W2, "rd0");

    // Dropping enable_i and changing inputs mid-request does not abort it
    issue(1'b0, 32'h0000_0400, '0, PAT_W1);
    repeat (3) @(negedge clk_i);
    enable_i = 1'b0;
    write_i  = 1'b1;
    addr_i   = 32'h0000_0060;
    data_i   = '1;
    wait_ack("abort");
    repeat (15) @(negedge clk_i);
    chk("abort_no_extra", 256'(sbq.size()), 256'(0));
    req(1'b0, 32'h0000_0060, '0, PAT_A5, "rd3_after_abort");

    // Reset during a write to line 7 discards the write
    @(negedge clk_i);
    enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h0000_00E0; data_i = PAT_W2;
    repeat (5) @(negedge clk_i);
    rst_i = 1'b0;
    enable_i = 1'b0;
    #1;
    chk("midrst_ack", 256'(ack_o), 256'(0));
    chk("midrst_data", data_o, '0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    repeat (12) @(negedge clk_i);
    req(1'b0, 32'h0000_00E0, '0, '0, "rd7");

    // LATENCY = 1 instance
    @(negedge clk_i);
    en1 = 1'b1; wr1 = 1'b0; addr1 = 32'h0000_00A0;
    @(negedge clk_i);
    chk("l1_busy_ack", 256'(ack1), 256'(0));
    en1 = 1'b0;
    @(negedge clk_i);
    chk("l1_rd_ack", 256'(ack1), 256'(1));
    chk("l1_rd_data", dout1, PAT_P1);
    @(negedge clk_i);
    chk("l1_ack_width", 256'(ack1), 256'(0));

    en1 = 1'b1; wr1 = 1'b1; addr1 = 32'h0000_00C0; din1 = PAT_W2;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("l1_wr_ack", 256'(ack1), 256'(1));
    chk("l1_wr_data_kept", dout1, PAT_P1);
    wr1 = 1'b0; din1 = '0;
    @(negedge clk_i);
    chk("l1_idle_gap", 256'(ack1), 256'(0));
    @(negedge clk_i);
    en1 = 1'b0;
    @(negedge clk_i);
    chk("l1_raw_ack", 256'(ack1), 256'(1));
    chk("l1_raw_data", dout1, PAT_W2);

    repeat (3) @(negedge clk_i);
    chk("sb_empty", 256'(sbq.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected completion");
    $fatal(1);
  end

endmodule
